// File: rtl/sha_ctrl_pkg.sv
// Shared constants and FSM state type for the SHA-256 candidate scheduler.
// The watchdog constants are only used when SHA_WDOG_EN is defined.
package sha_ctrl_pkg;

  localparam int         DIGEST_W     = 256;
  localparam int         MAX_LEN      = 4;
  localparam logic [7:0] CHARSET_BASE = 8'h61;
  localparam int         CHARSET_SIZE = 26;
  localparam logic [7:0] CHARSET_LAST = 8'(int'(CHARSET_BASE) + CHARSET_SIZE - 1);
  localparam int         CNT_W        = 32;
  localparam int         WDOG_CYCLES  = 256;
  localparam int         WDOG_W       = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/cand_odometer.sv
// Base-CHARSET_SIZE odometer over character bytes; byte len-1 is the fastest digit.
// Bytes at or above the active length are held at zero.
module cand_odometer
  import sha_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    inc,
  input  logic [2:0]              pw_len,
  output logic [MAX_LEN-1:0][7:0] cand,
  output logic                    last
);

  logic [2:0]              len_q;
  logic [MAX_LEN-1:0][7:0] cand_inc;

  // Ripple the carry from the fastest digit toward byte 0.
  always_comb begin
    logic carry;
    cand_inc = cand;
    carry    = 1'b1;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if (carry && (i < int'(len_q))) begin
        if (cand[i] == CHARSET_LAST) begin
          cand_inc[i] = CHARSET_BASE;
        end else begin
          cand_inc[i] = cand[i] + 8'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    last = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) && (cand[i] != CHARSET_LAST)) last = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand  <= '0;
      len_q <= '0;
    end else if (load) begin
      len_q <= pw_len;
      for (int i = 0; i < MAX_LEN; i++) begin
        cand[i] <= (i < int'(pw_len)) ? CHARSET_BASE : 8'h00;
      end
    end else if (inc) begin
      cand <= cand_inc;
    end
  end

endmodule

// File: rtl/sha_cand_sched.sv
// Brute-force candidate scheduler streaming fixed-length candidates into one SHA-256 core.
// Optional core-hang watchdog is enabled by defining SHA_WDOG_EN.
module sha_cand_sched
  import sha_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             pw_len,
  input  logic [DIGEST_W-1:0]    target_hash,
  output logic                   core_rst_n,
  output logic                   core_byte_rdy,
  output logic                   core_byte_stop,
  output logic [7:0]             core_data,
  input  logic [DIGEST_W-1:0]    core_digest,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   found,
  output logic                   exhausted,
  output logic [8*MAX_LEN-1:0]   match_pw,
  output logic [CNT_W-1:0]       cand_count,
  output logic                   wdog_err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t                  state;
  logic [2:0]              len_q;
  logic [2:0]              idx;
  logic [DIGEST_W-1:0]     target_q;
  logic [DIGEST_W-1:0]     digest_q;
  logic [MAX_LEN-1:0][7:0] cand;
  logic                    cand_last;
  logic                    start_ok;
  logic                    odo_load;
  logic                    odo_inc;

  assign start_ok = start && (pw_len != 3'd0) && (int'(pw_len) <= MAX_LEN);
  assign odo_load = start_ok && ((state == S_IDLE) || (state == S_DONE));
  assign odo_inc  = (state == S_NEXT);

  cand_odometer u_odometer (
    .clk    (clk),
    .rst    (rst),
    .load   (odo_load),
    .inc    (odo_inc),
    .pw_len (pw_len),
    .cand   (cand),
    .last   (cand_last)
  );

`ifdef SHA_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
`else
  assign wdog_err = 1'b0;
`endif

  // idx always points at the next byte to present, so FEED lasts exactly len_q cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      len_q          <= '0;
      idx            <= '0;
      target_q       <= '0;
      digest_q       <= '0;
      core_rst_n     <= 1'b1;
      core_byte_rdy  <= 1'b0;
      core_byte_stop <= 1'b0;
      core_data      <= '0;
      busy           <= 1'b0;
      found          <= 1'b0;
      exhausted      <= 1'b0;
      match_pw       <= '0;
      cand_count     <= '0;
`ifdef SHA_WDOG_EN
      wdog_cnt       <= '0;
      wdog_err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            len_q      <= pw_len;
            target_q   <= target_hash;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            match_pw   <= '0;
            cand_count <= '0;
            busy       <= 1'b1;
            core_rst_n <= 1'b0;
            state      <= S_CLEAR;
`ifdef SHA_WDOG_EN
            wdog_err   <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          core_rst_n    <= 1'b1;
          core_byte_rdy <= 1'b1;
          core_data     <= cand[0];
          idx           <= 3'd1;
          state         <= S_FEED;
        end
        S_FEED: begin
          if (idx == len_q) begin
            core_byte_rdy  <= 1'b0;
            core_byte_stop <= 1'b1;
            state          <= S_WAIT;
`ifdef SHA_WDOG_EN
            wdog_cnt       <= '0;
`endif
          end else begin
            core_data <= cand[idx[IDX_W-1:0]];
            idx       <= idx + 3'd1;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            digest_q       <= core_digest;
            core_byte_stop <= 1'b0;
            state          <= S_CHECK;
          end
`ifdef SHA_WDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            wdog_err       <= 1'b1;
            core_byte_stop <= 1'b0;
            busy           <= 1'b0;
            state          <= S_DONE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        S_CHECK: begin
          if (cand_count != '1) cand_count <= cand_count + CNT_W'(1);
          if (digest_q == target_q) begin
            found    <= 1'b1;
            match_pw <= cand;
            busy     <= 1'b0;
            state    <= S_DONE;
          end else if (cand_last) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          core_rst_n <= 1'b0;
          state      <= S_CLEAR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_cand_sched.sv
// Self-checking bench for sha_cand_sched: behavioural SHA core stand-in plus a
// rank-based reference for odometer order, match position and timing.
module tb_sha_cand_sched;

  localparam logic [255:0] SHA_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   pw_len;
  logic [255:0] target_hash;
  logic         core_rst_n;
  logic         core_byte_rdy;
  logic         core_byte_stop;
  logic [7:0]   core_data;
  logic [255:0] core_digest;
  logic         core_done;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  match_pw;
  logic [31:0]  cand_count;
  logic         wdog_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha_cand_sched dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pw_len         (pw_len),
    .target_hash    (target_hash),
    .core_rst_n     (core_rst_n),
    .core_byte_rdy  (core_byte_rdy),
    .core_byte_stop (core_byte_stop),
    .core_data      (core_data),
    .core_digest    (core_digest),
    .core_done      (core_done),
    .busy           (busy),
    .found          (found),
    .exhausted      (exhausted),
    .match_pw       (match_pw),
    .cand_count     (cand_count),
    .wdog_err       (wdog_err)
  );

  // Stand-in digest: real SHA-256 for "abc", otherwise a unique non-zero tag of the message.
  function automatic logic [255:0] fake_digest(input logic [31:0] m, input int len);
    if (len == 3 && m == 32'h0063_6261) return SHA_ABC;
    return {32'hC0DE_0000 | 32'(len), m, 192'h5A5A_1234_9876_FEDC_0F0F_F0F0_1357_2468_ACE0_BDF1_1111_2222};
  endfunction

  // Candidate number 'rank' in odometer order: byte len-1 is the least significant base-26 digit.
  function automatic logic [31:0] ref_cand(input int rank, input int len);
    logic [31:0] c;
    int r;
    c = '0;
    r = rank;
    for (int i = len - 1; i >= 0; i--) begin
      c[8*i +: 8] = 8'(97 + (r % 26));
      r = r / 26;
    end
    return c;
  endfunction

  bit          core_hang = 1'b0;
  int          core_lat  = 1;
  logic [31:0] msg;
  int          msg_len;
  int          stop_cnt;
  logic [31:0] log_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst || !core_rst_n) begin
      msg         = '0;
      msg_len     = 0;
      stop_cnt    = 0;
      core_done   <= 1'b0;
      core_digest <= '0;
    end else begin
      if (core_byte_rdy && msg_len < 4) begin
        msg[8*msg_len +: 8] = core_data;
        msg_len++;
      end
      if (core_byte_stop) begin
        if (stop_cnt == 0) log_q.push_back(msg);
        stop_cnt++;
        if (!core_hang && stop_cnt >= core_lat) begin
          core_done   <= 1'b1;
          core_digest <= fake_digest(msg, msg_len);
        end
      end
    end
  end

  task automatic pulse_start(input logic [2:0] len, input logic [255:0] tgt);
    @(negedge clk);
    pw_len      = len;
    target_hash = tgt;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pw_len = '0; target_hash = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (core_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_rst_n got=%b want=1", core_rst_n); end
    checks++; if ({busy, found, exhausted, wdog_err} !== 4'b0) begin errors++; $display("[TB] FAIL reset_status got=%b want=0000", {busy, found, exhausted, wdog_err}); end
    checks++; if ({core_byte_rdy, core_byte_stop} !== 2'b0) begin errors++; $display("[TB] FAIL reset_core_ctl got=%b want=00", {core_byte_rdy, core_byte_stop}); end
    checks++; if (core_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_core_data got=%h want=00", core_data); end
    checks++; if (match_pw !== 32'h0) begin errors++; $display("[TB] FAIL reset_match_pw got=%h want=0", match_pw); end
    checks++; if (cand_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_cand_count got=%0d want=0", cand_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_match_abc();
    bit ok;
    core_hang = 1'b0;
    core_lat  = int'($urandom_range(1, 4));
    log_q.delete();
    pulse_start(3'd3, SHA_ABC);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abc_busy_rise got=%b want=1", busy); end
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL abc_timeout got=busy want=idle"); end
    checks++; if (found !== 1'b1 || exhausted !== 1'b0) begin errors++; $display("[TB] FAIL abc_flags got found=%b exh=%b want 1/0", found, exhausted); end
    checks++; if (match_pw !== 32'h0063_6261) begin errors++; $display("[TB] FAIL abc_match_pw got=%h want=00636261", match_pw); end
    checks++; if (cand_count !== 32'd29) begin errors++; $display("[TB] FAIL abc_cand_count got=%0d want=29", cand_count); end
    checks++; if (log_q.size() != 29) begin errors++; $display("[TB] FAIL abc_fed_count got=%0d want=29", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== ref_cand(i, 3)) begin errors++; $display("[TB] FAIL abc_fed[%0d] got=%h want=%h", i, log_q[i], ref_cand(i, 3)); end
    end
  endtask

  task automatic test_exhaust();
    int busy_cycles;
    core_hang = 1'b0;
    core_lat  = 1;
    log_q.delete();
    pulse_start(3'd1, 256'h0);
    busy_cycles = 0;
    for (int n = 0; n < 1000 && busy; n++) begin
      busy_cycles++;
      @(negedge clk);
    end
    // 25 candidates of CLEAR+FEED+WAIT(2)+CHECK+NEXT, final one without NEXT.
    checks++; if (busy_cycles != 155) begin errors++; $display("[TB] FAIL exh_busy_cycles got=%0d want=155", busy_cycles); end
    checks++; if (found !== 1'b0 || exhausted !== 1'b1) begin errors++; $display("[TB] FAIL exh_flags got found=%b exh=%b want 0/1", found, exhausted); end
    checks++; if (cand_count !== 32'd26) begin errors++; $display("[TB] FAIL exh_cand_count got=%0d want=26", cand_count); end
    checks++; if (match_pw !== 32'h0) begin errors++; $display("[TB] FAIL exh_match_pw got=%h want=0", match_pw); end
    checks++; if (log_q.size() != 26) begin errors++; $display("[TB] FAIL exh_fed_count got=%0d want=26", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== ref_cand(i, 1)) begin errors++; $display("[TB] FAIL exh_fed[%0d] got=%h want=%h", i, log_q[i], ref_cand(i, 1)); end
    end
  endtask

  task automatic test_invalid_len();
    bit saw_busy;
    bit saw_rdy;
    saw_busy = 1'b0;
    saw_rdy  = 1'b0;
    pulse_start(3'd0, 256'h0);
    for (int n = 0; n < 6; n++) begin
      if (busy) saw_busy = 1'b1;
      if (core_byte_rdy) saw_rdy = 1'b1;
      @(negedge clk);
    end
    pulse_start(3'd5, 256'h0);
    for (int n = 0; n < 6; n++) begin
      if (busy) saw_busy = 1'b1;
      if (core_byte_rdy) saw_rdy = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_busy) begin errors++; $display("[TB] FAIL inv_busy got=1 want=0"); end
    checks++; if (saw_rdy) begin errors++; $display("[TB] FAIL inv_byte_rdy got=1 want=0"); end
    checks++; if (exhausted !== 1'b1 || cand_count !== 32'd26) begin errors++; $display("[TB] FAIL inv_sticky got exh=%b cnt=%0d want 1/26", exhausted, cand_count); end
  endtask

  task automatic test_random_match();
    bit          ok;
    int          len;
    int          total;
    int          rank;
    logic [31:0] want;
    for (int iter = 0; iter < 6; iter++) begin
      len   = int'($urandom_range(1, 4));
      total = 26 ** len;
      rank  = int'($urandom_range(0, (total - 1 < 300) ? total - 1 : 300));
      want  = ref_cand(rank, len);
      core_hang = 1'b0;
      core_lat  = int'($urandom_range(1, 5));
      log_q.delete();
      pulse_start(3'(len), fake_digest(want, len));
      wait_idle(8000, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rnd%0d_timeout got=busy want=idle", iter); end
      checks++; if (found !== 1'b1 || exhausted !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_flags got found=%b exh=%b want 1/0", iter, found, exhausted); end
      checks++; if (match_pw !== want) begin errors++; $display("[TB] FAIL rnd%0d_match_pw got=%h want=%h", iter, match_pw, want); end
      checks++; if (cand_count !== 32'(rank + 1)) begin errors++; $display("[TB] FAIL rnd%0d_cand_count got=%0d want=%0d", iter, cand_count, rank + 1); end
      checks++; if (log_q.size() != rank + 1) begin errors++; $display("[TB] FAIL rnd%0d_fed_count got=%0d want=%0d", iter, log_q.size(), rank + 1); end
      for (int i = 0; i < log_q.size(); i++) begin
        if (log_q[i] !== ref_cand(i, len)) begin
          checks++; errors++;
          $display("[TB] FAIL rnd%0d_fed[%0d] got=%h want=%h", iter, i, log_q[i], ref_cand(i, len));
          break;
        end
      end
    end
  endtask

  task automatic test_reset_mid_feed();
    bit ok;
    core_hang = 1'b0;
    core_lat  = 2;
    log_q.delete();
    pulse_start(3'd3, fake_digest(ref_cand(2, 3), 3));
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (core_byte_rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (!ok || core_byte_rdy !== 1'b1) begin errors++; $display("[TB] FAIL mid_second_byte got rdy=%b want=1", core_byte_rdy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (core_byte_rdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_abort got rdy=%b busy=%b want 0/0", core_byte_rdy, busy); end
    checks++; if (core_rst_n !== 1'b1 || cand_count !== 32'h0) begin errors++; $display("[TB] FAIL mid_abort_state got rst_n=%b cnt=%0d want 1/0", core_rst_n, cand_count); end
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    pulse_start(3'd3, fake_digest(ref_cand(2, 3), 3));
    wait_idle(500, ok);
    checks++; if (!ok || found !== 1'b1 || cand_count !== 32'd3) begin errors++; $display("[TB] FAIL mid_restart got found=%b cnt=%0d want 1/3", found, cand_count); end
    checks++; if (log_q.size() == 0 || log_q[0] !== 32'h0061_6161) begin errors++; $display("[TB] FAIL mid_restart_first got=%h want=00616161", (log_q.size() == 0) ? 32'h0 : log_q[0]); end
  endtask

  task automatic test_watchdog();
    int n;
    bit ok;
    core_hang = 1'b1;
    pulse_start(3'd1, 256'h0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (core_byte_stop) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wdog_wait_entry got=no_stop want=stop"); end
`ifdef SHA_WDOG_EN
    n = 0;
    while (!wdog_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 256) begin errors++; $display("[TB] FAIL wdog_latency got=%0d want=256", n); end
    checks++; if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin errors++; $display("[TB] FAIL wdog_flags got busy=%b found=%b exh=%b want 0/0/0", busy, found, exhausted); end
`else
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (wdog_err !== 1'b0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("[TB] FAIL wdog_tied got=%0d_cycles_high want=0", n); end
    checks++; if (busy !== 1'b1 || core_byte_stop !== 1'b1) begin errors++; $display("[TB] FAIL wdog_blocking got busy=%b stop=%b want 1/1", busy, core_byte_stop); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    core_hang = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_match_abc();
    test_exhaust();
    test_invalid_len();
    test_random_match();
    test_reset_mid_feed();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_cand_sched.md
# sha_cand_sched

Brute-force candidate scheduler for the `top_sha` SHA-256 core in the password cracker. It generates fixed-length lowercase password candidates in odometer order and streams each one byte-serially into the core. After each digest it compares the result against a target hash, then either reports the match or advances to the next candidate until the key space is exhausted. It sits between the host/UART command logic and a single SHA-256 core instance.

## Interface
- `MAX_LEN`, 4: maximum candidate length in bytes.
- `CHARSET_BASE`, 8'h61: first character code ('a').
- `CHARSET_SIZE`, 26: number of characters; last char = `CHARSET_BASE+CHARSET_SIZE-1`.
- `WDOG_CYCLES`, 256: watchdog limit in cycles; used only with `SHA_WDOG_EN`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a search.
- `pw_len` in 3: candidate length; valid range 1..`MAX_LEN`; sampled at start.
- `target_hash` in 256: digest to match; sampled at start.
- `core_rst_n` out 1: active-low clear to the core.
- `core_byte_rdy` out 1: byte valid to the core.
- `core_byte_stop` out 1: end-of-message to the core.
- `core_data` out 8: candidate byte.
- `core_digest` in 256: core hash output.
- `core_done` in 1: core digest valid; level or pulse.
- `busy` out 1: search in progress.
- `found` out 1: match found; sticky until next accepted start.
- `exhausted` out 1: key space done with no match; sticky.
- `match_pw` out 8*`MAX_LEN`: matching candidate; byte 0 in bits [7:0]; unused bytes are 0.
- `cand_count` out 32: number of candidates checked.
- `wdog_err` out 1: core hang detected.

## Operation
- FSM states: IDLE, CLEAR, FEED, WAIT, CHECK, NEXT, DONE.
- IDLE/DONE:
  - `start` with valid `pw_len` latches `pw_len` and `target_hash`.
  - It loads the candidate with all bytes = `CHARSET_BASE` and clears `found`, `exhausted`, `wdog_err`, `cand_count` and `match_pw`.
  - Next state is CLEAR.
  - `start` with `pw_len` of 0 or greater than `MAX_LEN` is ignored.
- CLEAR: `core_rst_n`=0 for exactly one cycle, then FEED.
- FEED:
  - `core_byte_rdy`=1 with `core_data`=cand[idx].
  - idx runs 0..pw_len-1, one byte per cycle.
  - After the last byte, go to WAIT.
- WAIT:
  - `core_byte_rdy`=0 and `core_byte_stop`=1, held until `core_done`=1.
  - Then latch `core_digest` and go to CHECK.
- CHECK:
  - Increment `cand_count`.
  - If the digest equals the target, set `found`, load `match_pw` and go to DONE.
  - Otherwise, if every byte is the last char, set `exhausted` and go to DONE.
  - Otherwise go to NEXT.
- NEXT:
  - Odometer increment: byte pw_len-1 is the fastest digit.
  - A digit wraps from the last char to `CHARSET_BASE` with carry into the next lower index.
  - Then go to CLEAR.
- `start` while `busy` is ignored.
- `busy`=1 in every state except IDLE and DONE.

## Timing
- Reset values:
  - FSM in IDLE.
  - All outputs 0, except `core_rst_n`=1.
  - Candidate, `cand_count` and latched digest cleared.
- All outputs are registered.
- `busy` rises on the cycle after the `start` edge.
- Cycles per candidate = 1 (CLEAR) + pw_len (FEED) + W (WAIT, ≥1) + 1 (CHECK) + 1 (NEXT); NEXT is skipped on the final candidate.
- `found`/`exhausted` assert on the CHECK→DONE edge, in the same cycle `busy` falls.
- `core_done` is only sampled in WAIT; if it is asserted in any other state it is ignored.
- `rst` mid-search aborts immediately: `core_byte_rdy`=0 with no further bytes, and the FSM returns to IDLE.
- `cand_count` saturates at 32'hFFFF_FFFF.

## Configuration
- `SHA_WDOG_EN` defined:
  - A WAIT-state counter runs; if `core_done` has not arrived after `WDOG_CYCLES` cycles, set `wdog_err`=1 (sticky) and go to DONE with `found`=`exhausted`=0.
  - The counter clears on entry to WAIT.
- `SHA_WDOG_EN` undefined: no counter, WAIT blocks indefinitely, and `wdog_err` is tied to 0.

## Structure
- Package `sha_ctrl_pkg` holds:
  - the FSM state enum;
  - `DIGEST_W`=256;
  - charset constants;
  - the `cand_count` width.
- Sub-module `cand_odometer` implements the base-`CHARSET_SIZE` byte counter. It provides load, increment and a `last` flag, with active length `pw_len`.
- The comparator and FSM remain in `sha_cand_sched`.

## Test plan
- Reset values: assert `rst` → all outputs 0, `core_rst_n`=1, `busy`=0.
- Match on "abc": `pw_len`=3, target = SHA-256("abc") = ba7816bf…f20015ad → expected response:
  - bytes fed per candidate are 61,61,61 first, and 61,62,63 on the matching candidate;
  - `found`=1 with `match_pw`[23:0]=24'h636261;
  - `cand_count`=29.
- Exhaustion: `pw_len`=1, target=0 → 26 candidates 61..7A are fed, then `exhausted`=1, `found`=0, `cand_count`=26.
- Invalid length: `start` with `pw_len`=0, then `pw_len`=5 → `busy` stays 0 and no `core_byte_rdy` is seen.
- Reset mid-FEED: assert `rst` on the second byte → outputs drop on the same edge; after release plus `start`, the search restarts at "aaa".
- Watchdog (`SHA_WDOG_EN`): core model never asserts `core_done` → `wdog_err`=1 exactly 256 cycles after WAIT entry, and `busy`=0.
